// File: rtl/any1_pit_mc.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// any1_pit_mc -- multi-channel programmable interval timer for the ANY-1 bus
//
// NCH identical CW-bit down-counters. Each channel has a maxcount reload
// value, an ontime compare point that drives its out pin high, and a control
// register. The channels share a sync register that loads and starts several
// channels in the same cycle, plus latched interrupt status and enable bits.
//
// Optional build macro: ANY1_PIT_PRESCALE_EN
//   defined   -> control[31:16] is a per-channel prescale value P; count
//                decrements once every P+1 ticks
//   undefined -> control[31:16] reads 0; every tick decrements count
//
// Ports:
//   clk_i, rst_i     system clock, synchronous active-high reset
//   cs_i/cyc_i/stb_i block select, bus cycle, bus strobe
//   ack_o            bus acknowledge (writes same cycle, reads next cycle)
//   sel_i[3:0]       byte lane selects for writes
//   we_i             write enable
//   adr_i[7:0]       byte address
//   dat_i[31:0]      write data
//   dat_o[31:0]      registered read data, valid with ack_o
//   clk_x[NCH-1:0]   external count clocks (asynchronous)
//   gate[NCH-1:0]    gate inputs (asynchronous)
//   out[NCH-1:0]     timer outputs
//   irq_o            OR of (irq_stat & irq_en)
// ---------------------------------------------------------------------------
module any1_pit_mc #(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cs_i,
  input  logic           cyc_i,
  input  logic           stb_i,
  output logic           ack_o,
  input  logic [3:0]     sel_i,
  input  logic           we_i,
  input  logic [7:0]     adr_i,
  input  logic [31:0]    dat_i,
  output logic [31:0]    dat_o,
  input  logic [NCH-1:0] clk_x,
  input  logic [NCH-1:0] gate,
  output logic [NCH-1:0] out,
  output logic           irq_o
);

  logic cs, wr, rd_ack_q;
  logic sync_hit, stat_hit, en_hit;
  logic [31:0] rdata;

  logic [CW-1:0]  count_q  [NCH];
  logic [CW-1:0]  maxc_q   [NCH];
  logic [CW-1:0]  ontime_q [NCH];
  logic [NCH-1:0] ce_q, ar_q, xc_q, ge_q, rt_q;
  logic [NCH-1:0] irq_stat_q, irq_en_q;

  logic [NCH-1:0] x_s1, x_s2, x_s3, g_s1, g_s2, g_s3;
  logic [NCH-1:0] x_rise, g_rise;

  logic [NCH-1:0] ch_hit, wr_max, wr_on, wr_ctl;
  logic [NCH-1:0] ld_pulse, ce_set, reload, tick, step, term, irq_clr;

`ifdef ANY1_PIT_PRESCALE_EN
  logic [15:0] psc_val_q [NCH];
  logic [15:0] psc_cnt_q [NCH];
  logic [15:0] psc_next  [NCH];
`endif

  // Replace only the byte lanes selected by sel_i
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  assign cs     = cs_i & cyc_i & stb_i;
  assign wr     = cs & we_i;
  // Reads wait one cycle for the registered dat_o; writes complete at once
  assign ack_o  = cs & (we_i | rd_ack_q);
  assign irq_o  = |(irq_stat_q & irq_en_q);
  assign x_rise = x_s2 & ~x_s3;
  assign g_rise = g_s2 & ~g_s3;

  assign sync_hit = (adr_i == 8'h80);
  assign stat_hit = (adr_i == 8'h84);
  assign en_hit   = (adr_i == 8'h88);

  // Address decode, write strobes, per-channel tick/reload qualification and
  // the read mux. A terminal count (term) is only taken when no reload is
  // competing, since reload has the highest priority.
  always_comb begin
    rdata   = '0;
    irq_clr = (wr & stat_hit & sel_i[0]) ? dat_i[NCH-1:0] : '0;
    for (int n = 0; n < NCH; n++) begin
      ch_hit[n]   = ~adr_i[7] & (adr_i[6:4] == 3'(n)) & (adr_i[1:0] == 2'b00);
      wr_max[n]   = wr & ch_hit[n] & (adr_i[3:2] == 2'd1);
      wr_on[n]    = wr & ch_hit[n] & (adr_i[3:2] == 2'd2);
      wr_ctl[n]   = wr & ch_hit[n] & (adr_i[3:2] == 2'd3);
      ld_pulse[n] = (wr_ctl[n] & sel_i[0] & dat_i[0]) |
                    (wr & sync_hit & sel_i[0] & dat_i[n]);
      ce_set[n]   = wr & sync_hit & sel_i[1] & dat_i[8+n];
      tick[n]     = ce_q[n] & (xc_q[n] ? x_rise[n] : 1'b1) &
                    (ge_q[n] ? g_s2[n] : 1'b1);
      reload[n]   = ld_pulse[n] | (rt_q[n] & g_rise[n]);
`ifdef ANY1_PIT_PRESCALE_EN
      // A prescale value written in the same cycle as ld is used right away
      psc_next[n] = psc_val_q[n];
      if (wr_ctl[n] & sel_i[2]) psc_next[n][7:0]  = dat_i[23:16];
      if (wr_ctl[n] & sel_i[3]) psc_next[n][15:8] = dat_i[31:24];
      step[n]     = tick[n] & (psc_cnt_q[n] == 16'd0);
`else
      step[n]     = tick[n];
`endif
      term[n]     = step[n] & ~reload[n] & (count_q[n] == '0);

      if (ch_hit[n]) begin
        case (adr_i[3:2])
          2'd0:    rdata = 32'(count_q[n]);
          2'd1:    rdata = 32'(maxc_q[n]);
          2'd2:    rdata = 32'(ontime_q[n]);
          default: rdata = {
`ifdef ANY1_PIT_PRESCALE_EN
                            psc_val_q[n],
`else
                            16'd0,
`endif
                            10'd0, rt_q[n], ge_q[n], xc_q[n], ar_q[n],
                            ce_q[n], 1'b0};
        endcase
      end
    end
    if (stat_hit) rdata = 32'(irq_stat_q);
    if (en_hit)   rdata = 32'(irq_en_q);
  end

  // Bus response, synchronisers, interrupt bits and the counter channels.
  // Within a channel the later assignments win: a control write overrides
  // the sync-register ce set, which overrides the one-shot ce clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ack_q   <= 1'b0;
      dat_o      <= '0;
      out        <= '0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      ce_q       <= '0;
      ar_q       <= '1;
      xc_q       <= '0;
      ge_q       <= '0;
      rt_q       <= '0;
      x_s1       <= '0;
      x_s2       <= '0;
      x_s3       <= '0;
      g_s1       <= '0;
      g_s2       <= '0;
      g_s3       <= '0;
      for (int n = 0; n < NCH; n++) begin
        count_q[n]  <= '0;
        maxc_q[n]   <= '0;
        ontime_q[n] <= '0;
`ifdef ANY1_PIT_PRESCALE_EN
        psc_val_q[n] <= '0;
        psc_cnt_q[n] <= '0;
`endif
      end
    end else begin
      rd_ack_q   <= cs & ~we_i;
      dat_o      <= (cs & ~we_i) ? rdata : '0;
      x_s1       <= clk_x;
      x_s2       <= x_s1;
      x_s3       <= x_s2;
      g_s1       <= gate;
      g_s2       <= g_s1;
      g_s3       <= g_s2;
      irq_stat_q <= (irq_stat_q & ~irq_clr) | term;
      if (wr & en_hit & sel_i[0]) irq_en_q <= dat_i[NCH-1:0];

      for (int n = 0; n < NCH; n++) begin
        if (wr_max[n]) maxc_q[n]   <= CW'(merge_bytes(32'(maxc_q[n]), dat_i, sel_i));
        if (wr_on[n])  ontime_q[n] <= CW'(merge_bytes(32'(ontime_q[n]), dat_i, sel_i));

        if (reload[n]) begin
          count_q[n] <= maxc_q[n];
        end else if (term[n]) begin
          out[n] <= 1'b0;
          if (ar_q[n]) count_q[n] <= maxc_q[n];
        end else if (step[n]) begin
          if (count_q[n] == ontime_q[n]) out[n] <= 1'b1;
          count_q[n] <= count_q[n] - CW'(1);
        end

`ifdef ANY1_PIT_PRESCALE_EN
        psc_val_q[n] <= psc_next[n];
        if (reload[n])
          psc_cnt_q[n] <= psc_next[n];
        else if (tick[n])
          psc_cnt_q[n] <= step[n] ? psc_next[n] : psc_cnt_q[n] - 16'd1;
`endif

        if (term[n] & ~ar_q[n]) ce_q[n] <= 1'b0;
        if (ce_set[n])          ce_q[n] <= 1'b1;
        if (wr_ctl[n] & sel_i[0]) begin
          ce_q[n] <= dat_i[1];
          ar_q[n] <= dat_i[2];
          xc_q[n] <= dat_i[3];
          ge_q[n] <= dat_i[4];
          rt_q[n] <= dat_i[5];
        end
      end
    end
  end

endmodule

// File: tb/tb_any1_pit_mc.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_any1_pit_mc -- directed self-checking bench for any1_pit_mc (NCH=4,
// CW=32). Each test_* task drives one scenario and compares DUT outputs
// against hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_any1_pit_mc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cs_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]  sel_i = 4'h0;
  logic [7:0]  adr_i = 8'h00;
  logic [31:0] dat_i = 32'h0;
  logic [3:0]  clk_x = 4'h0, gate = 4'h0;
  logic        ack_o, irq_o;
  logic [31:0] dat_o;
  logic [3:0]  out;

  int total = 0;
  int bad   = 0;

  any1_pit_mc #(.NCH(4), .CW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
    .ack_o(ack_o), .sel_i(sel_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_o), .clk_x(clk_x), .gate(gate), .out(out), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_idle();
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    bus_idle();
    clk_x = 4'h0;
    gate  = 4'h0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One write; it takes effect on the next rising edge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = a; dat_i = d; sel_i = s;
    @(posedge clk_i);
    #1;
    bus_idle();
  endtask

  // One read; returns dat_o once ack_o is seen, bounded to 4 cycles
  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk_i);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    adr_i = a; sel_i = 4'hF;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i);
      #1;
      if (ack_o === 1'b1) got = 1'b1;
    end
    d = dat_o;
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL read_timeout adr=%h got no ack, required ack within 4 cycles", a);
    end
    bus_idle();
  endtask

  task automatic pulse_x0();
    @(negedge clk_i);
    clk_x[0] = 1'b1;
    repeat (3) @(negedge clk_i);
    clk_x[0] = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  // Reset values of every register plus read/write ack timing
  task automatic test_reset();
    logic [31:0] d, exp;
    do_reset();
    total++;
    if (out !== 4'h0) begin bad++; $display("[TB] FAIL rst_out got=%h exp=0", out); end
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_irq got=%b exp=0", irq_o); end
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_ack got=%b exp=0", ack_o); end

    @(negedge clk_i);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = 8'h8C; dat_i = 32'hFFFF_FFFF; sel_i = 4'hF;
    #1;
    total++;
    if (ack_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_ack_same_cycle got=%b exp=1", ack_o); end
    @(posedge clk_i);
    #1;
    bus_idle();

    @(negedge clk_i);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    adr_i = 8'h0C; sel_i = 4'hF;
    #1;
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_ack_early got=%b exp=0", ack_o); end
    @(posedge clk_i);
    #1;
    total++;
    if (ack_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_ack_next got=%b exp=1", ack_o); end
    total++;
    if (dat_o !== 32'h4) begin bad++; $display("[TB] FAIL rd_ack_data got=%h exp=00000004", dat_o); end
    bus_idle();

    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 4; r++) begin
        bus_read(8'(ch * 16 + r * 4), d);
        exp = (r == 3) ? 32'h4 : 32'h0;
        total++;
        if (d !== exp) begin
          bad++;
          $display("[TB] FAIL rst_reg ch=%0d reg=%0d got=%h exp=%h", ch, r, d, exp);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      bus_read(8'(8'h80 + k * 4), d);
      total++;
      if (d !== 32'h0) begin bad++; $display("[TB] FAIL rst_glob idx=%0d got=%h exp=0", k, d); end
    end
  endtask

  // Channel 0 auto-reload: maxcount 4, ontime 2
  task automatic test_periodic();
    logic [31:0] d;
    logic [31:0] exp_cnt [6] = '{4, 3, 2, 1, 0, 4};
    logic        exp_out [6] = '{0, 0, 1, 1, 0, 0};
    do_reset();
    bus_write(8'h04, 32'd4, 4'hF);
    bus_write(8'h08, 32'd2, 4'hF);
    bus_write(8'h0C, 32'h7, 4'hF);
    for (int k = 0; k < 6; k++) begin
      bus_read(8'h00, d);
      total++;
      if (d !== exp_cnt[k]) begin bad++; $display("[TB] FAIL per_count k=%0d got=%0d exp=%0d", k, d, exp_cnt[k]); end
      total++;
      if (out[0] !== exp_out[k]) begin bad++; $display("[TB] FAIL per_out k=%0d got=%b exp=%b", k, out[0], exp_out[k]); end
    end
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL per_irq_masked got=%b exp=0", irq_o); end
    bus_read(8'h84, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("[TB] FAIL per_stat got=%h exp=1", d); end
    bus_write(8'h88, 32'h1, 4'hF);
    total++;
    if (irq_o !== 1'b1) begin bad++; $display("[TB] FAIL per_irq_en got=%b exp=1", irq_o); end
    bus_write(8'h0C, 32'h4, 4'hF);
    bus_write(8'h84, 32'h1, 4'hF);
    bus_read(8'h84, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL per_w1c got=%h exp=0", d); end
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL per_irq_clr got=%b exp=0", irq_o); end
  endtask

  // One-shot with a W1C clear landing on the terminal-count cycle
  task automatic test_oneshot();
    logic [31:0] d;
    do_reset();
    bus_write(8'h04, 32'd3, 4'hF);
    bus_write(8'h0C, 32'h3, 4'hF);
    repeat (3) @(posedge clk_i);
    bus_write(8'h84, 32'h1, 4'hF);
    bus_read(8'h84, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("[TB] FAIL os_set_beats_clr got=%h exp=1", d); end
    repeat (4) @(posedge clk_i);
    bus_read(8'h0C, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL os_ctl got=%h exp=0", d); end
    bus_read(8'h00, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL os_count got=%h exp=0", d); end
    bus_write(8'h84, 32'h1, 4'h1);
    bus_read(8'h84, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL os_w1c got=%h exp=0", d); end
  endtask

  // External clock counting and gate freeze
  task automatic test_extclk();
    logic [31:0] d;
    do_reset();
    bus_write(8'h04, 32'd20, 4'hF);
    bus_write(8'h0C, 32'hB, 4'hF);
    repeat (5) @(posedge clk_i);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'd20) begin bad++; $display("[TB] FAIL xc_idle got=%0d exp=20", d); end
    for (int k = 0; k < 10; k++) pulse_x0();
    repeat (5) @(posedge clk_i);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'd10) begin bad++; $display("[TB] FAIL xc_count got=%0d exp=10", d); end
    bus_write(8'h0C, 32'h1A, 4'hF);
    for (int k = 0; k < 3; k++) pulse_x0();
    repeat (5) @(posedge clk_i);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'd10) begin bad++; $display("[TB] FAIL gate_freeze got=%0d exp=10", d); end
    @(negedge clk_i);
    gate[0] = 1'b1;
    repeat (4) @(posedge clk_i);
    for (int k = 0; k < 2; k++) pulse_x0();
    repeat (5) @(posedge clk_i);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'd8) begin bad++; $display("[TB] FAIL gate_open got=%0d exp=8", d); end
  endtask

  // Sync register loads and starts all four channels together
  task automatic test_sync_start();
    logic [31:0] d;
    logic [31:0] exp_cnt [4] = '{6, 5, 4, 3};
    do_reset();
    for (int ch = 0; ch < 4; ch++) bus_write(8'(ch * 16 + 4), 32'd6, 4'hF);
    bus_write(8'h80, 32'h0F0F, 4'h3);
    for (int ch = 0; ch < 4; ch++) begin
      bus_read(8'(ch * 16), d);
      total++;
      if (d !== exp_cnt[ch]) begin bad++; $display("[TB] FAIL sync_count ch=%0d got=%0d exp=%0d", ch, d, exp_cnt[ch]); end
    end
    bus_read(8'h80, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL sync_read got=%h exp=0", d); end
    bus_read(8'h3C, d);
    total++;
    if (d !== 32'h6) begin bad++; $display("[TB] FAIL sync_ctl3 got=%h exp=6", d); end
  endtask

  // Gate rising edge reloads a one-shot mid-count, 3 cycles after the pin
  task automatic test_retrigger();
    logic [31:0] d;
    logic [31:0] exp_cnt [4] = '{6, 5, 10, 9};
    do_reset();
    bus_write(8'h04, 32'd10, 4'hF);
    bus_write(8'h0C, 32'h23, 4'hF);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    gate[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus_read(8'h00, d);
      total++;
      if (d !== exp_cnt[k]) begin bad++; $display("[TB] FAIL retrig k=%0d got=%0d exp=%0d", k, d, exp_cnt[k]); end
    end
  endtask

  // Upper control bits and, when built in, the prescaler
  task automatic test_prescale();
    logic [31:0] d;
    logic [31:0] exp_ctl;
`ifdef ANY1_PIT_PRESCALE_EN
    logic [31:0] exp_cnt [7] = '{9, 9, 9, 8, 8, 8, 7};
    exp_ctl = 32'hFFFF_0004;
`else
    exp_ctl = 32'h0000_0004;
`endif
    do_reset();
    bus_write(8'h1C, 32'hFFFF_0004, 4'hF);
    bus_read(8'h1C, d);
    total++;
    if (d !== exp_ctl) begin bad++; $display("[TB] FAIL ctl_upper got=%h exp=%h", d, exp_ctl); end
`ifdef ANY1_PIT_PRESCALE_EN
    bus_write(8'h04, 32'd9, 4'hF);
    bus_write(8'h0C, 32'h0002_0003, 4'hF);
    for (int k = 0; k < 7; k++) begin
      bus_read(8'h00, d);
      total++;
      if (d !== exp_cnt[k]) begin bad++; $display("[TB] FAIL psc_count k=%0d got=%0d exp=%0d", k, d, exp_cnt[k]); end
    end
`endif
  endtask

  // Reset in the middle of a count clears everything
  task automatic test_reset_abort();
    logic [31:0] d;
    do_reset();
    bus_write(8'h04, 32'd50, 4'hF);
    bus_write(8'h0C, 32'h7, 4'hF);
    repeat (5) @(posedge clk_i);
    do_reset();
    bus_read(8'h00, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL abort_count got=%0d exp=0", d); end
    bus_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL abort_max got=%0d exp=0", d); end
  endtask

  initial begin
    $display("[TB] starting any1_pit_mc bench");
    test_reset();
    test_periodic();
    test_oneshot();
    test_extclk();
    test_sync_start();
    test_retrigger();
    test_prescale();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/any1_pit_mc.md
Name: any1_pit_mc

Overview:
- Parametrised multi-channel programmable interval timer for the ANY-1 peripheral bus. It is the next generation of the three-channel PIT.
- NCH identical down-counters, each with a configurable width and its own control register.
- Adds a per-channel interrupt with latched status and enable, plus a global synchronous start/load register.
- Adds a one-shot retrigger on gate rising edge.
- Sits on the I/O bus beside the interrupt controller; irq_o feeds one interrupt controller input.

Parameters:
- NCH, 4, number of channels, 1..8.
- CW, 32, counter width in bits, 8..32. Register reads are zero-extended; writes are truncated to CW.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cs_i  in  1  block select
- cyc_i  in  1  bus cycle
- stb_i  in  1  bus strobe
- ack_o  out  1  bus acknowledge
- sel_i  in  4  byte lane selects
- we_i  in  1  write enable
- adr_i  in  8  byte address
- dat_i  in  32  write data
- dat_o  out  32  registered read data
- clk_x  in  NCH  external count clocks, asynchronous, one bit per channel
- gate  in  NCH  gate inputs, asynchronous
- out  out  NCH  timer outputs
- irq_o  out  1  OR of (irq_stat & irq_en)

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high; it is sampled only on the rising edge of clk_i.
- Bus handshake:
  - cs = cs_i & cyc_i & stb_i.
  - Writes: ack_o = cs, in the same cycle.
  - Reads: ack_o asserts on the cycle after cs is first seen and stays high while cs remains high. dat_o is valid with ack.
  - ack_o = 0 whenever cs = 0.
  - Register writes honour sel_i per byte lane.
- Address map:
  - Channel n occupies n*0x10, for n < NCH.
  - +0x0 count, read-only.
  - +0x4 maxcount.
  - +0x8 ontime.
  - +0xC control.
  - 0x80 sync register:
    - Bits [7:0] load-all mask: pulses ld for each set bit.
    - Bits [15:8] enable-all mask: sets ce for each set bit.
    - Write-only; reads return 0.
  - 0x84 irq_stat: write-1-to-clear.
  - 0x88 irq_en.
  - Unmapped addresses read 0; writes to them are ignored.
- Control register bits:
  - 0: ld. Self-clearing pulse; always reads 0.
  - 1: ce, count enable.
  - 2: ar, auto-reload.
  - 3: xc, external clock.
  - 4: ge, gate enable.
  - 5: rt, gate-retrigger.
- Input synchronisation: clk_x and gate each pass through a 2-flop synchroniser, then a rising-edge detector. Total latency is 3 clk_i cycles from the pin to the tick or retrigger.
- Tick condition: tick[n] = ce & (xc ? clk_x rising edge : 1) & (ge ? synchronised gate : 1).
- Counter update, per channel, in priority order:
  1. ld, or a retrigger (rt = 1 and gate rising edge): count <= maxcount. out is unchanged.
  2. Tick with count == 0:
     - out <= 0.
     - irq_stat[n] <= 1.
     - If ar = 1, count <= maxcount; otherwise ce <= 0 and count holds at 0.
  3. Tick with count == ontime, where count != 0: out <= 1 and count <= count - 1.
  4. Other tick: count <= count - 1.
- Boundary conditions:
  - ontime = 0 or ontime > maxcount: out never goes high.
  - maxcount = 0 with ar = 1: terminal count on every tick.
- Simultaneous events:
  - A hardware irq_stat set beats a W1C clear in the same cycle.
  - A sync-register ld for a channel and a control write to the same channel in the same cycle: ld = 1; all other control fields take the control-write values.
- Reset values:
  - count = maxcount = ontime = 0.
  - ce = ld = ge = xc = rt = 0; ar = 1.
  - out = 0, irq_stat = 0, irq_en = 0, dat_o = 0, ack_o = 0.
  - Synchronisers cleared.
  - A reset asserted mid-count aborts the count immediately.

Optional Feature:
- Macro: ANY1_PIT_PRESCALE_EN.
- Defined:
  - Control bits [31:16] form a per-channel prescale value P.
  - A 16-bit prescale counter divides the raw tick by P+1; count decrements only when the prescaler reaches 0 and then reloads to P.
  - The prescaler reloads on ld or retrigger and is reset to 0.
- Undefined:
  - Control bits [31:16] read 0 and writes to them are ignored.
  - Every tick decrements count.

Test Plan:
- Reset; read every register -> all 0 except control ar bit = 1 (reads 0x4). ack_o arrives 1 cycle after cs for reads, same cycle for writes.
- Channel 0 periodic: maxcount = 4, ontime = 2, control = 0x7 -> count sequence 4,3,2,1,0,4,... out high from the tick at count 2 until the tick at count 0. irq_stat[0] sets every 5 cycles; irq_o = 1 only after irq_en[0] is written 1.
- One-shot: ar = 0, maxcount = 3 -> counts to 0, then ce reads 0 and count holds at 0. A W1C write of 1 to irq_stat in the same cycle as a terminal count leaves bit = 1.
- External clock: xc = 1, 10 clk_x rising edges spaced ≥ 4 clk_i apart, maxcount = 20 -> count = 10. Gate low with ge = 1 freezes count.
- Sync start: write 0x0F0F to 0x80 with NCH = 4 and equal maxcount -> all four counts equal on every following cycle. Retrigger with rt = 1 and a gate pulse mid-count -> count reloads to maxcount 3 cycles after the pin edge.
- With ANY1_PIT_PRESCALE_EN, P = 2 -> count decrements once every 3 cycles. With the macro undefined, the upper control bits read 0.
